// File: rtl/psum_ofifo.sv
// Column-parallel output FIFO: each array column pushes psums into its own circular
// buffer at its own skewed cycle; whole rows are popped only once every column has data.
module psum_ofifo #(
  parameter int col     = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2 * bw + 3,
  parameter int depth   = 8,
  parameter int ptr_w   = $clog2(depth)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*bw_psum-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);

  localparam logic [ptr_w:0] full_cnt = (ptr_w + 1)'(depth);

  logic [bw_psum-1:0]     mem_q   [col][depth];
  logic [ptr_w-1:0]       wptr_q  [col];
  logic [ptr_w-1:0]       wptr_d  [col];
  logic [ptr_w:0]         count_q [col];
  logic [ptr_w:0]         count_d [col];
  logic [ptr_w-1:0]       rptr_q;
  logic [ptr_w-1:0]       rptr_d;
  logic [col*bw_psum-1:0] out_q;
  logic [col*bw_psum-1:0] out_d;
  logic                   overflow_q;
  logic                   overflow_d;
  logic [col-1:0]         not_empty;
  logic [col-1:0]         is_full;
  logic [col-1:0]         push_en;
  logic                   pop_acc;

  always_comb begin
    not_empty = '0;
    is_full   = '0;
    for (int c = 0; c < col; c++) begin
      not_empty[c] = (count_q[c] != '0);
      is_full[c]   = (count_q[c] == full_cnt);
    end
  end

  // Flags come only from registered counts, so in/wr never reach an output combinationally.
  assign o_valid    = &not_empty;
  assign o_full     = |is_full;
  assign o_ready    = ~o_full;
  assign o_overflow = overflow_q;
  assign out        = out_q;
  assign pop_acc    = rd & o_valid;

  always_comb begin
    push_en    = '0;
    out_d      = out_q;
    rptr_d     = rptr_q + ptr_w'(pop_acc);
    for (int c = 0; c < col; c++) begin
      wptr_d[c]  = wptr_q[c];
      count_d[c] = count_q[c];
    end
    for (int c = 0; c < col; c++) begin
      // A full column still accepts a push when the same-cycle pop frees a slot.
      push_en[c] = wr[c] & (~is_full[c] | pop_acc);
      wptr_d[c]  = wptr_q[c] + ptr_w'(push_en[c]);
      count_d[c] = count_q[c] + (ptr_w + 1)'(push_en[c]) - (ptr_w + 1)'(pop_acc);
      if (pop_acc) begin
        out_d[c*bw_psum +: bw_psum] = mem_q[c][rptr_q];
      end
    end
    overflow_d = overflow_q | (|(wr & ~push_en));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c]  <= '0;
        count_q[c] <= '0;
      end
      rptr_q     <= '0;
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c]  <= wptr_d[c];
        count_q[c] <= count_d[c];
      end
      rptr_q     <= rptr_d;
      out_q      <= out_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; the cleared counts make any stale contents unreachable.
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (push_en[c]) begin
        mem_q[c][wptr_q[c]] <= in[c*bw_psum +: bw_psum];
      end
    end
  end

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed bench for psum_ofifo: stimulus pushes hand-computed popped rows into a queue,
// a monitor compares them with out after every accepted pop.
module tb_psum_ofifo;
  localparam int COL = 8;
  localparam int BWP = 19;
  localparam int W   = COL * BWP;

  logic           clk;
  logic           reset;
  logic [W-1:0]   in;
  logic [COL-1:0] wr;
  logic           rd;
  logic [W-1:0]   out;
  logic           o_valid;
  logic           o_full;
  logic           o_ready;
  logic           o_overflow;

  int n_vec;
  int n_err;
  logic [W-1:0] exp_q[$];

  psum_ofifo dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .wr         (wr),
    .rd         (rd),
    .out        (out),
    .o_valid    (o_valid),
    .o_full     (o_full),
    .o_ready    (o_ready),
    .o_overflow (o_overflow)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] row_f(input int base, input int stride);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < COL; c++) r[c*BWP +: BWP] = BWP'(base + stride * c);
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: inputs driven at a falling edge, returns at the next falling edge.
  task automatic step(input logic [COL-1:0] w, input logic [W-1:0] d, input logic r);
    wr = w;
    in = d;
    rd = r;
    @(negedge clk);
    wr = '0;
    in = '0;
    rd = 1'b0;
  endtask

  task automatic pop_exp(input logic [W-1:0] row);
    exp_q.push_back(row);
    step('0, '0, 1'b1);
  endtask

  task automatic mid_cycle_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_out"}, out, '0);
    chk({tag, "_valid"}, W'(o_valid), W'(0));
    chk({tag, "_full"}, W'(o_full), W'(0));
    chk({tag, "_ready"}, W'(o_ready), W'(1));
    chk({tag, "_ovf"}, W'(o_overflow), W'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    logic fire;
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      fire = rd && o_valid && !reset;
      @(negedge clk);
      if (fire) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pop_unexpected: got %h expected no pop", out);
        end else begin
          e = exp_q.pop_front();
          if (out !== e) begin
            n_err++;
            $display("FAIL pop_row: got %h expected %h", out, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: got no end of stimulus expected end within 200000");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    logic [W-1:0] d;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    wr    = '0;
    in    = '0;
    rd    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset / idle, then a mid-cycle reset after a real pop made out nonzero
    chk("rst_out", out, '0);
    chk("rst_ready", W'(o_ready), W'(1));
    step('1, row_f(7, 3), 1'b0);
    pop_exp(row_f(7, 3));
    step('1, row_f(50, 1), 1'b0);
    mid_cycle_reset("rst_mid");
    step('0, '0, 1'b1);
    chk("idle_rd_out0", out, '0);
    step('0, '0, 1'b1);
    chk("idle_rd_out1", out, '0);
    chk("idle_rd_valid", W'(o_valid), W'(0));

    // skewed fill: one column per cycle
    for (int c = 0; c < COL; c++) begin
      d = '0;
      d[c*BWP +: BWP] = BWP'(100 + c);
      step(COL'(1) << c, d, 1'b0);
      chk($sformatf("skew_valid_%0d", c), W'(o_valid), W'(c == COL - 1));
    end
    pop_exp(row_f(100, 1));
    chk("skew_valid_after", W'(o_valid), W'(0));

    // fill to full, drain, then refill across the pointer wrap
    for (int r = 0; r < 8; r++) begin
      step('1, row_f(16 * r, 1), 1'b0);
      chk($sformatf("fill_full_%0d", r), W'(o_full), W'(r == 7));
    end
    chk("fill_ready", W'(o_ready), W'(0));
    for (int r = 0; r < 8; r++) pop_exp(row_f(16 * r, 1));
    chk("drain_valid", W'(o_valid), W'(0));
    chk("drain_ready", W'(o_ready), W'(1));
    for (int r = 8; r < 16; r++) step('1, row_f(16 * r, 1), 1'b0);
    chk("refill_full", W'(o_full), W'(1));

    // full + pop + push on every column
    exp_q.push_back(row_f(16 * 8, 1));
    step('1, row_f(8'h55, 0), 1'b1);
    chk("pp_full", W'(o_full), W'(1));
    chk("pp_ovf", W'(o_overflow), W'(0));
    for (int r = 9; r < 16; r++) pop_exp(row_f(16 * r, 1));
    pop_exp(row_f(8'h55, 0));
    chk("pp_empty", W'(o_valid), W'(0));

    // overflow on column 3 only
    for (int r = 20; r < 28; r++) step('1, row_f(16 * r, 1), 1'b0);
    d = '0;
    d[3*BWP +: BWP] = BWP'(19'h7777);
    step(COL'(8), d, 1'b0);
    chk("ovf_set", W'(o_overflow), W'(1));
    chk("ovf_full", W'(o_full), W'(1));
    for (int r = 20; r < 28; r++) pop_exp(row_f(16 * r, 1));
    chk("ovf_sticky", W'(o_overflow), W'(1));
    chk("ovf_empty", W'(o_valid), W'(0));

    // pop on partial: only column 0 holds data
    d = '0;
    d[0 +: BWP] = BWP'(19'h1FFFF);
    step(COL'(1), d, 1'b0);
    step('0, '0, 1'b1);
    chk("partial_out_hold", out, row_f(16 * 27, 1));
    chk("partial_valid", W'(o_valid), W'(0));
    d = row_f(19'h12340, 1);
    d[0 +: BWP] = '0;
    d[1*BWP +: BWP] = BWP'(19'h7FFFF);
    step(COL'(8'hFE), d, 1'b0);
    chk("partial_valid_all", W'(o_valid), W'(1));
    d[0 +: BWP] = BWP'(19'h1FFFF);
    pop_exp(d);
    chk("partial_ovf_sticky", W'(o_overflow), W'(1));

    // mid-operation reset discards a stored row and the sticky flag
    step('1, row_f(3, 5), 1'b0);
    mid_cycle_reset("rst_mid2");
    step('0, '0, 1'b1);
    chk("rst_mid2_discard", W'(o_valid), W'(0));
    chk("rst_mid2_out", out, '0);

    @(negedge clk);
    chk("queue_drained", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
